// File: rtl/uart_pkt_parser.sv
// Frames UART receiver bytes into HDR/ADDR/LEN/payload packets and streams verified payloads out.
// Define UART_PKT_CHKSUM_EN to require and verify a trailing mod-256 checksum byte.
module uart_pkt_parser #(
    parameter logic [7:0] HDR_BYTE    = 8'hAA,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 480
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] in_dat,
    input  logic       in_flag,
    input  logic       pd_rdy,
    output logic [7:0] pd_dat,
    output logic       pd_vld,
    output logic       pd_last,
    output logic [7:0] pkt_addr,
    output logic [7:0] pkt_len,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [1:0] err_code
);
    // state | meaning
    // IDLE  | hunting for HDR_BYTE, other bytes dropped
    // ADDR  | waiting for address byte
    // LEN   | waiting for length byte, range checked
    // DATA  | storing payload bytes
    // CHK   | waiting for checksum byte (checksum build only)
    // DRAIN | streaming stored payload downstream

    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
`ifdef UART_PKT_CHKSUM_EN
    localparam logic [1:0] E_SUM = 2'd0;
`endif
    localparam logic [1:0] E_LEN = 2'd1;
    localparam logic [1:0] E_TMO = 2'd2;
    localparam logic [1:0] E_OVR = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
`ifdef UART_PKT_CHKSUM_EN
        S_CHK,
`endif
        S_DRAIN
    } state_t;

    state_t        state, state_nxt;
    logic          flag_d;
    logic          byte_stb;
    logic          counting;
    logic          accept;
    logic          mem_we;
    logic [7:0]    addr_q, addr_nxt;
    logic [7:0]    len_q, len_nxt;
    logic [PW-1:0] wr_ptr, wr_ptr_nxt;
    logic [PW-1:0] rd_ptr, rd_ptr_nxt;
    logic [15:0]   to_cnt, to_nxt;
    logic [7:0]    pkt_addr_nxt, pkt_len_nxt;
    logic          ok_nxt, err_nxt;
    logic [1:0]    code_nxt;
    logic [7:0]    pay_mem [MAX_LEN];
`ifdef UART_PKT_CHKSUM_EN
    logic [7:0]    sum_q, sum_nxt;
`endif

    assign byte_stb = in_flag & ~flag_d;
    assign counting = (state != S_IDLE) && (state != S_DRAIN);
    assign pd_vld   = (state == S_DRAIN);
    assign pd_dat   = pd_vld ? pay_mem[rd_ptr] : 8'h00;
    assign pd_last  = pd_vld && (8'(rd_ptr) == (pkt_len - 8'd1));

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr_q;
        len_nxt      = len_q;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        pkt_addr_nxt = pkt_addr;
        pkt_len_nxt  = pkt_len;
        ok_nxt       = 1'b0;
        err_nxt      = 1'b0;
        code_nxt     = err_code;
        mem_we       = 1'b0;
        accept       = 1'b0;
`ifdef UART_PKT_CHKSUM_EN
        sum_nxt      = sum_q;
`endif
        to_nxt       = (byte_stb || !counting) ? 16'd0 : to_cnt + 16'd1;

        case (state)
            S_IDLE: begin
                if (byte_stb && in_dat == HDR_BYTE) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (byte_stb) begin
                    addr_nxt  = in_dat;
`ifdef UART_PKT_CHKSUM_EN
                    sum_nxt   = in_dat;
`endif
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (byte_stb) begin
`ifdef UART_PKT_CHKSUM_EN
                    sum_nxt = sum_q + in_dat;
`endif
                    if (in_dat == 8'd0 || in_dat > 8'(MAX_LEN)) begin
                        err_nxt   = 1'b1;
                        code_nxt  = E_LEN;
                        state_nxt = S_IDLE;
                    end else begin
                        len_nxt    = in_dat;
                        wr_ptr_nxt = '0;
                        state_nxt  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (byte_stb) begin
                    mem_we = 1'b1;
`ifdef UART_PKT_CHKSUM_EN
                    sum_nxt = sum_q + in_dat;
`endif
                    // Pointer stops at len-1 so it never wraps at MAX_LEN.
                    if (8'(wr_ptr) == (len_q - 8'd1)) begin
`ifdef UART_PKT_CHKSUM_EN
                        state_nxt = S_CHK;
`else
                        accept = 1'b1;
`endif
                    end else begin
                        wr_ptr_nxt = wr_ptr + PW'(1);
                    end
                end
            end
`ifdef UART_PKT_CHKSUM_EN
            S_CHK: begin
                if (byte_stb) begin
                    if (in_dat == sum_q) begin
                        accept = 1'b1;
                    end else begin
                        err_nxt   = 1'b1;
                        code_nxt  = E_SUM;
                        state_nxt = S_IDLE;
                    end
                end
            end
`endif
            S_DRAIN: begin
                if (byte_stb) begin
                    err_nxt  = 1'b1;
                    code_nxt = E_OVR;
                end
                if (pd_rdy) begin
                    if (pd_last) state_nxt = S_IDLE;
                    else         rd_ptr_nxt = rd_ptr + PW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // A strobe in the same cycle as the timeout wins.
        if (counting && !byte_stb && to_cnt == 16'(TIMEOUT_CYC - 1)) begin
            err_nxt   = 1'b1;
            code_nxt  = E_TMO;
            state_nxt = S_IDLE;
            to_nxt    = 16'd0;
        end

        if (accept) begin
            pkt_addr_nxt = addr_q;
            pkt_len_nxt  = len_q;
            ok_nxt       = 1'b1;
            rd_ptr_nxt   = '0;
            state_nxt    = S_DRAIN;
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            flag_d   <= 1'b1;
            addr_q   <= 8'h00;
            len_q    <= 8'h00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            to_cnt   <= 16'd0;
            pkt_addr <= 8'h00;
            pkt_len  <= 8'h00;
            pkt_ok   <= 1'b0;
            pkt_err  <= 1'b0;
            err_code <= 2'b00;
`ifdef UART_PKT_CHKSUM_EN
            sum_q    <= 8'h00;
`endif
        end else begin
            state    <= state_nxt;
            flag_d   <= in_flag;
            addr_q   <= addr_nxt;
            len_q    <= len_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            to_cnt   <= to_nxt;
            pkt_addr <= pkt_addr_nxt;
            pkt_len  <= pkt_len_nxt;
            pkt_ok   <= ok_nxt;
            pkt_err  <= err_nxt;
            err_code <= code_nxt;
`ifdef UART_PKT_CHKSUM_EN
            sum_q    <= sum_nxt;
`endif
        end
    end

    // Payload store is not reset; it is only visible while draining.
    always_ff @(posedge sys_clk) begin
        if (mem_we) pay_mem[wr_ptr] <= in_dat;
    end

endmodule
